// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase REQ/ACK clock-domain-crossing handshake with an ACK synchronizer.
// Optional REQ_HIGH watchdog is compiled in with the CDC_HS_TIMEOUT_EN macro.
module cdc_hs_tx #(
    parameter int BUS_WIDTH      = 8,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] DATA_IN,
    input  logic                 VALID_IN,
    output logic                 READY_OUT,
    input  logic                 ACK_ASYNC,
    output logic                 REQ_OUT,
    output logic [BUS_WIDTH-1:0] DATA_OUT,
    output logic                 DONE_PULSE,
    output logic                 TIMEOUT_ERR
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REQ_HIGH = 2'd1;
    localparam logic [1:0] REQ_LOW  = 2'd2;

    logic [NUM_STAGES-1:0] ack_sync_reg;
    logic [NUM_STAGES-1:0] ack_sync_next;
    logic                  ack_s;

    logic [1:0]            state_reg, state_next;
    logic                  req_reg, req_next;
    logic [BUS_WIDTH-1:0]  data_reg, data_next;
    logic                  done_reg, done_next;
    logic                  accept;
    logic                  timeout_hit;
    logic                  suppress_done;

    // Shift chain: stage 0 samples the asynchronous ACK, each later stage samples its predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign ack_sync_next[gi] = ACK_ASYNC;
            end else begin : g_rest
                assign ack_sync_next[gi] = ack_sync_reg[gi-1];
            end
        end
    endgenerate

    assign ack_s  = ack_sync_reg[NUM_STAGES-1];
    assign accept = (state_reg == IDLE) && VALID_IN;

`ifdef CDC_HS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             terr_reg, terr_next;

    assign timeout_hit = (state_reg == REQ_HIGH) && !ack_s &&
                         (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    // A timed-out transfer still passes through REQ_LOW; the sticky flag masks its DONE_PULSE.
    assign suppress_done = terr_reg;

    always_comb begin
        cnt_next  = cnt_reg;
        terr_next = terr_reg;
        if (accept) begin
            cnt_next  = '0;
            terr_next = 1'b0;
        end else if (state_reg == REQ_HIGH && !ack_s) begin
            cnt_next = cnt_reg + 1'b1;
            if (timeout_hit) begin
                terr_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_reg  <= '0;
            terr_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            terr_reg <= terr_next;
        end
    end

    assign TIMEOUT_ERR = terr_reg;
`else
    assign timeout_hit   = 1'b0;
    assign suppress_done = 1'b0;
    assign TIMEOUT_ERR   = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        data_next  = data_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (VALID_IN) begin
                    data_next  = DATA_IN;
                    req_next   = 1'b1;
                    state_next = REQ_HIGH;
                end
            end
            REQ_HIGH: begin
                if (ack_s || timeout_hit) begin
                    req_next   = 1'b0;
                    state_next = REQ_LOW;
                end
            end
            REQ_LOW: begin
                if (!ack_s) begin
                    state_next = IDLE;
                    done_next  = !suppress_done;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_sync_reg <= '0;
            state_reg    <= IDLE;
            req_reg      <= 1'b0;
            data_reg     <= '0;
            done_reg     <= 1'b0;
        end else begin
            ack_sync_reg <= ack_sync_next;
            state_reg    <= state_next;
            req_reg      <= req_next;
            data_reg     <= data_next;
            done_reg     <= done_next;
        end
    end

    assign READY_OUT  = (state_reg == IDLE);
    assign REQ_OUT    = req_reg;
    assign DATA_OUT   = data_reg;
    assign DONE_PULSE = done_reg;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Scoreboard bench for cdc_hs_tx: directed transfers, a delayed ACK responder model and a DONE/REQ monitor.
// Build with CDC_HS_TIMEOUT_EN defined to exercise the watchdog path instead of the indefinite wait.
module tb_cdc_hs_tx;

`ifdef CDC_HS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       ack_async = 1'b0;
    logic       req_out;
    logic [7:0] data_out;
    logic       done_pulse;
    logic       timeout_err;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];
    bit         ack_en = 1'b1;
    logic       ack_pend = 1'b0;
    logic       req_prev = 1'b0;

    cdc_hs_tx #(.BUS_WIDTH(8), .NUM_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(clk), .RST(rst_n), .DATA_IN(data_in), .VALID_IN(valid_in), .READY_OUT(ready_out),
        .ACK_ASYNC(ack_async), .REQ_OUT(req_out), .DATA_OUT(data_out),
        .DONE_PULSE(done_pulse), .TIMEOUT_ERR(timeout_err)
    );

    always #5 clk = ~clk;

    // Destination model: follows REQ_OUT with one full cycle of lag.
    always @(negedge clk) begin
        ack_async = ack_pend;
        ack_pend  = ack_en && req_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: word on REQ rise must be the head of the queue; each DONE_PULSE retires one word.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_out && !req_prev) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: got REQ rise data 0x%0h expected none", data_out);
                end else begin
                    chk("data_at_req", {24'h0, data_out}, {24'h0, exp_q[0]});
                end
            end
            if (done_pulse) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got DONE_PULSE data 0x%0h expected none", data_out);
                end else begin
                    chk("data_at_done", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
                end
            end
        end
        req_prev = req_out;
    end

    // Offers a word; returns 1 ns after the accepting edge (VALID dropped) or at that edge if keep=1.
    task automatic send(input logic [7:0] w, input bit keep);
        bit ok = 1'b0;
        exp_q.push_back(w);
        @(negedge clk);
        data_in  = w;
        valid_in = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (ready_out) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_accept: got no acceptance of 0x%0h expected one within 200 cycles", w);
        end
        if (!keep) begin
            #1 valid_in = 1'b0;
        end
    endtask

    task automatic wait_done(input int target, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got done count %0d expected %0d within 100 cycles", name, done_cnt, target);
        end
    endtask

    initial begin
        int base;
        int bad;

        // Reset state
        #3;
        chk("rst_req", {31'h0, req_out}, 32'h0);
        chk("rst_ready", {31'h0, ready_out}, 32'h1);
        chk("rst_data", {24'h0, data_out}, 32'h0);
        chk("rst_done", {31'h0, done_pulse}, 32'h0);
        chk("rst_terr", {31'h0, timeout_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic transfer 0xA5, cycle-exact timing
        base = done_cnt;
        send(8'hA5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("basic_req_ready_high", {30'h0, req_out, ready_out}, 32'h2);
            chk("basic_data_high", {24'h0, data_out}, 32'hA5);
        end
        @(negedge clk);
        chk("basic_req_drop", {30'h0, req_out, ready_out}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("basic_wait_low", {29'h0, req_out, done_pulse, ready_out}, 32'h0);
            chk("basic_data_low", {24'h0, data_out}, 32'hA5);
        end
        @(negedge clk);
        chk("basic_done", {30'h0, done_pulse, ready_out}, 32'h3);
        @(negedge clk);
        chk("basic_done_once", {30'h0, done_pulse, ready_out}, 32'h1);
        chk("basic_done_cnt", done_cnt, base + 1);
        $display("transfer basic 0xA5: data_out=0x%0h done_cnt=%0d", data_out, done_cnt);

        // Back-to-back 0x11 then 0x22 with VALID held high
        base = done_cnt;
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        wait_done(base + 2, "b2b_done");
        @(negedge clk);
        chk("b2b_data_final", {24'h0, data_out}, 32'h22);
        $display("transfer back-to-back 0x11,0x22: data_out=0x%0h done_cnt=%0d", data_out, done_cnt);

        // Busy-time input change is ignored
        base = done_cnt;
        send(8'h5A, 1'b0);
        @(negedge clk);
        data_in  = 8'hFF;
        valid_in = 1'b1;
        @(negedge clk);
        chk("busy_data_hold", {24'h0, data_out}, 32'h5A);
        @(negedge clk);
        valid_in = 1'b0;
        wait_done(base + 1, "busy_done");
        repeat (12) @(negedge clk);
        chk("busy_no_extra", done_cnt, base + 1);
        chk("busy_data_idle", {24'h0, data_out}, 32'h5A);
        chk("busy_idle", {30'h0, req_out, ready_out}, 32'h1);
        $display("transfer busy 0x5A with 0xFF offered: data_out=0x%0h done_cnt=%0d", data_out, done_cnt);

        // Asynchronous reset mid-transfer, then 0x3C
        send(8'h77, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_req_before_rst", {31'h0, req_out}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, req_out}, 32'h0);
        chk("mid_rst_data", {24'h0, data_out}, 32'h0);
        chk("mid_rst_ready", {31'h0, ready_out}, 32'h1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        base = done_cnt;
        exp_q.push_back(8'h3C);
        data_in  = 8'h3C;
        valid_in = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        chk("post_rst_first_edge", {23'h0, req_out, data_out}, 32'h13C);
        wait_done(base + 1, "post_rst_done");
        $display("transfer after reset 0x3C: data_out=0x%0h done_cnt=%0d", data_out, done_cnt);

`ifdef CDC_HS_TIMEOUT_EN
        // Watchdog: ACK never raised
        ack_en = 1'b0;
        base = done_cnt;
        send(8'hC3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_req_high", {30'h0, req_out, timeout_err}, 32'h2);
        end
        @(negedge clk);
        chk("to_req_drop", {30'h0, req_out, timeout_err}, 32'h1);
        exp_q.delete();
        @(negedge clk);
        chk("to_no_done", {31'h0, done_pulse}, 32'h0);
        @(negedge clk);
        chk("to_ready", {30'h0, ready_out, timeout_err}, 32'h3);
        repeat (4) @(negedge clk);
        chk("to_done_cnt", done_cnt, base);
        chk("to_sticky", {31'h0, timeout_err}, 32'h1);
        ack_en = 1'b1;
        send(8'h0F, 1'b0);
        @(negedge clk);
        chk("to_cleared", {31'h0, timeout_err}, 32'h0);
        wait_done(base + 1, "to_next_done");
        $display("transfer timeout 0xC3 then 0x0F: terr=%0d done_cnt=%0d", timeout_err, done_cnt);
`else
        // No watchdog: REQ held while ACK is withheld
        ack_en = 1'b0;
        base = done_cnt;
        send(8'h99, 1'b0);
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (req_out !== 1'b1 || timeout_err !== 1'b0) bad++;
        end
        chk("nowd_req_held_bad_cycles", bad, 0);
        chk("nowd_done_cnt", done_cnt, base);
        ack_en = 1'b1;
        wait_done(base + 1, "nowd_done");
        $display("transfer withheld ACK 0x99: data_out=0x%0h done_cnt=%0d", data_out, done_cnt);
`endif

        repeat (4) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1, "bench watchdog expired");
    end

endmodule
